store_buffer: RTL

- Write-buffer stage directly upstream of the single-cycle core's data memory. It owns the memory's only address/writeEn/write_data port.
- Core stores are queued in a small FIFO and drained to memory one word per cycle while the port is idle.
- Core loads take the port combinationally; a load is served from the buffer when it hits a queued store.
- A flush/empty pair lets the control unit drain all pending stores, e.g. before halt or a memory dump.

---
 rtl/store_buffer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer between the core and a single-ported data memory: queues stores, drains them
// in order, and arbitrates loads onto the port. Define STB_FORWARD_EN to forward loads from queued stores.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_address,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_address,
  output logic [DATA_W-1:0] ld_data,
  input  logic              flush,
  output logic              empty,
  output logic              mem_writeEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;
  typedef enum logic [1:0] {PORT_IDLE, PORT_LOAD, PORT_DRAIN} port_e;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  ptr_t  head_q, head_d;
  ptr_t  tail_q, tail_d;
  cnt_t  count_q, count_d;
  port_e owner;

  logic full;
  logic push;
  logic pop;
  logic ld_hit;
  logic ld_servable;

  assign full     = (count_q == cnt_t'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full && !flush && !reset;
  assign push     = st_valid && st_ready;
  assign pop      = (owner == PORT_DRAIN) && !reset;

`ifdef STB_FORWARD_EN
  logic [DATA_W-1:0] fwd_data;

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    ld_hit   = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((cnt_t'(i) < count_q) && (addr_q[head_q + ptr_t'(i)] == ld_address)) begin
        ld_hit   = 1'b1;
        fwd_data = data_q[head_q + ptr_t'(i)];
      end
    end
  end

  assign ld_servable = !full;
  assign ld_data     = ld_hit ? fwd_data : mem_read_data;
`else
  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((cnt_t'(i) < count_q) && (addr_q[head_q + ptr_t'(i)] == ld_address)) begin
        ld_hit = 1'b1;
      end
    end
  end

  // A load that hits a queued store waits until that store has reached memory.
  assign ld_servable = !full && !ld_hit;
  assign ld_data     = mem_read_data;
`endif

  always_comb begin
    if (full) begin
      owner = PORT_DRAIN;
    end else if (ld_valid && ld_servable) begin
      owner = PORT_LOAD;
    end else if (count_q != '0) begin
      owner = PORT_DRAIN;
    end else begin
      owner = PORT_IDLE;
    end
  end

  always_comb begin
    mem_writeEn    = 1'b0;
    mem_address    = ld_address;
    mem_write_data = '0;
    ld_ready       = 1'b0;
    unique case (owner)
      PORT_LOAD: begin
        ld_ready = !reset;
      end
      PORT_DRAIN: begin
        mem_writeEn    = !reset;
        mem_address    = addr_q[head_q];
        mem_write_data = data_q[head_q];
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    head_d  = pop  ? head_q + ptr_t'(1) : head_q;
    tail_d  = push ? tail_q + ptr_t'(1) : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= st_address;
      data_q[tail_q] <= st_data;
    end
  end

endmodule
